if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
Parametrised instruction-fetch stage with a decoupling buffer. It generates sequential PCs and issues requests to a synchronous instruction memory with fixed 1-cycle read latency. Returned instructions and their PCs are buffered in a DEPTH-entry FIFO and presented to decode over a valid/ready handshake. A redirect (branch/jump) flushes all buffered and in-flight fetches and restarts fetch at the new PC.

Parameters:
XLEN, 32, address/PC width
INSN_W, 32, instruction width
DEPTH, 4, FIFO entries (power of 2, >=2)
RESET_PC, 0, PC fetched first after reset
CNT_W, 32, perf counter width (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
redirect_valid  in  1  redirect request from execute
redirect_pc  in  XLEN  redirect target
imem_req  out  1  memory read request this cycle
imem_addr  out  XLEN  read address, valid when imem_req
imem_rdata  in  INSN_W  read data, valid the cycle after imem_req
out_valid  out  1  buffered instruction available
out_ready  in  1  decode accepts
out_pc  out  XLEN  PC of head entry
out_insn  out  INSN_W  instruction of head entry

Behaviour:
- Reset (rst=0, async): pc_q=RESET_PC, FIFO empty (count=0), inflight_q=0, out_valid=0, imem_req=0. All outputs 0 except imem_addr=RESET_PC.
- Credit rule: normal request issued iff !redirect_valid && (count + inflight_q) < DEPTH. On issue: imem_addr=pc_q, pc_q <= pc_q+4, mod 2^XLEN; wrap from all-ones region is allowed.
- Redirect cycle: target = {redirect_pc[XLEN-1:2],2'b00}. imem_req=1 and imem_addr=target, regardless of credit. pc_q <= target+4. FIFO cleared. Any in-flight response arriving this cycle is discarded.
- Response: inflight_q/inflight_pc_q register a request. Next cycle imem_rdata is pushed with inflight_pc_q, unless a redirect occurs in that cycle.
- Latency: request at cycle N -> push at end of N+1 -> out_valid at N+2. The FIFO is registered, with no bypass.
- Pop: out_valid && out_ready. Simultaneous push+pop keeps count unchanged. Credit makes push-when-full impossible; an assertion checks this.
- Redirect with out_valid && out_ready in the same cycle: the pop counts as accepted, then the flush applies. out_valid=0 the next cycle.
- out_pc/out_insn hold stable while out_valid && !out_ready.
- Steady state with out_ready=1: one instruction per cycle after a 2-cycle fill.
- Reset mid-operation: immediate return to reset values. An in-flight response after reset release is ignored, because inflight_q=0.

Optional Feature:
IF_PERF_CNT_EN.
- Defined: adds outputs perf_fetched, perf_flushed, perf_stall, each CNT_W wide, all reset to 0. They saturate at all-ones.
  - perf_fetched: +1 per pop.
  - perf_flushed: +count+inflight_q entries discarded per redirect.
  - perf_stall: +1 per cycle with out_ready=1 && out_valid=0 and no redirect.
- Undefined: these ports and their logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package if_pkg:
  - addr_t (XLEN) and insn_t (INSN_W).
  - fetch_entry_t struct {pc, insn}.
  - PC_STEP=4 constant.
  - Default XLEN/INSN_W constants.
- Sub-module fetch_fifo: parametrised DEPTH x fetch_entry_t synchronous FIFO with push/pop/flush and count output. It is also reused later for the decode queue.
- Top: PC register, credit logic, in-flight tracking, perf counters.

Test Plan:
1. Reset release, RESET_PC=0x100, out_ready=1, memory returns addr^0xA5A5: cycles 0..3 imem_addr = 0x100, 0x104, 0x108, 0x10C. out_valid first at cycle 2 with out_pc=0x100, then one entry per cycle.
2. out_ready=0 from start, DEPTH=4: exactly 4 requests issued, then imem_req stays 0. Head holds 0x100. Raising out_ready resumes fetch at 0x110 with no gap or duplicate.
3. redirect_valid=1, redirect_pc=0x2003, with 3 entries queued and 1 in flight: imem_addr=0x2000 that cycle and out_valid=0 next cycle. The next popped PC is 0x2000, and no stale PC appears.
4. Redirect coinciding with a handshake pop of 0x104: 0x104 is counted as consumed and the next out_pc is the redirect target.
5. RESET_PC=0xFFFF_FFF8: PC sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
6. Assert rst=0 asynchronously mid-stream with the FIFO half full: outputs clear without a clock edge. After release, fetch restarts at RESET_PC and no pre-reset response is pushed.
   - With IF_PERF_CNT_EN: counters read 0 after reset, and perf_flushed=4 after scenario 3.

Source files
------------

// File: rtl/if_pkg.sv
// Shared fetch-path types and constants: default address/instruction widths,
// the buffered fetch entry, and the sequential PC increment.
package if_pkg;

   localparam int XLEN_DEF   = 32;
   localparam int INSN_W_DEF = 32;
   localparam int PC_STEP    = 4;

   typedef logic [XLEN_DEF-1:0]   addr_t;
   typedef logic [INSN_W_DEF-1:0] insn_t;

   typedef struct packed {
      addr_t pc;
      insn_t insn;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry registered FIFO of fetch entries with push/pop/flush and an
// occupancy count; the head is read straight from storage (no bypass).
module fetch_fifo
   import if_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = fetch_entry_t
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  entry_t                   push_data_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   output logic                     valid_o,
   output entry_t                   head_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CW-1:0] count_q;
   entry_t        mem_q [DEPTH];
   logic          do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   assign valid_o = (count_q != '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(push_i) - CW'(do_pop);
      end
   end

   // Upstream credit accounting must never let a push land on a full queue.
   assert property (@(posedge clk) disable iff (!rst)
      !(push_i && !flush_i && count_q == CW'(DEPTH)));

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch with credit-limited sequential PC generation, 1-cycle memory
// response tracking and a decoupling FIFO. `define IF_PERF_CNT_EN adds perf counters.
module if_fetch_queue
   import if_pkg::*;
#(
   parameter int               XLEN     = XLEN_DEF,
   parameter int               INSN_W   = INSN_W_DEF,
   parameter int               DEPTH    = 4,
   parameter logic [XLEN-1:0]  RESET_PC = '0
`ifdef IF_PERF_CNT_EN
   , parameter int             CNT_W    = 32
`endif
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               redirect_valid,
   input  logic [XLEN-1:0]    redirect_pc,
   output logic               imem_req,
   output logic [XLEN-1:0]    imem_addr,
   input  logic [INSN_W-1:0]  imem_rdata,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [XLEN-1:0]    out_pc,
   output logic [INSN_W-1:0]  out_insn
`ifdef IF_PERF_CNT_EN
   , output logic [CNT_W-1:0] perf_fetched
   , output logic [CNT_W-1:0] perf_flushed
   , output logic [CNT_W-1:0] perf_stall
`endif
);

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [INSN_W-1:0] insn;
   } entry_t;

   localparam int CW = $clog2(DEPTH) + 1;

   logic [XLEN-1:0] pc_q, pc_d, inflight_pc_q, inflight_pc_d, target;
   logic            inflight_q, inflight_d;
   logic [CW-1:0]   count;
   logic [CW:0]     occupancy;
   logic            credit_ok, issue, redirect, push, pop;
   entry_t          head;
   logic            unused_lsbs;

   assign unused_lsbs = ^redirect_pc[1:0];
   assign target      = {redirect_pc[XLEN-1:2], 2'b00};
   assign redirect    = rst && redirect_valid;

   // Buffered plus in-flight entries never exceed DEPTH, so a response always has room.
   assign occupancy = {1'b0, count} + (CW+1)'(inflight_q);
   assign credit_ok = occupancy < (CW+1)'(DEPTH);
   assign issue     = rst && !redirect_valid && credit_ok;

   assign imem_req      = redirect || issue;
   assign imem_addr     = redirect ? target : pc_q;
   assign inflight_d    = imem_req;
   assign inflight_pc_d = imem_addr;

   always_comb begin
      pc_d = pc_q;
      if (redirect)   pc_d = target + XLEN'(PC_STEP);
      else if (issue) pc_d = pc_q + XLEN'(PC_STEP);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   // A response returning in a redirect cycle belongs to the squashed path.
   assign push = inflight_q && !redirect_valid;
   assign pop  = out_valid && out_ready;

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i ('{pc: inflight_pc_q, insn: imem_rdata}),
      .pop_i       (pop),
      .flush_i     (redirect_valid),
      .valid_o     (out_valid),
      .head_o      (head),
      .count_o     (count)
   );

   assign out_pc   = head.pc;
   assign out_insn = head.insn;

`ifdef IF_PERF_CNT_EN
   logic [CNT_W-1:0] fetched_q, flushed_q, stall_q;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetched_q <= '0;
         flushed_q <= '0;
         stall_q   <= '0;
      end else begin
         if (pop) fetched_q <= sat_add(fetched_q, CNT_W'(1));
         if (redirect_valid) flushed_q <= sat_add(flushed_q, CNT_W'(occupancy));
         if (out_ready && !out_valid && !redirect_valid) stall_q <= sat_add(stall_q, CNT_W'(1));
      end
   end

   assign perf_fetched = fetched_q;
   assign perf_flushed = flushed_q;
   assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: fill latency, credit back-pressure, redirect
// flush, PC wrap and asynchronous reset, with a 1-cycle addr^0xA5A5 memory model.
module tb_if_fetch_queue;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // instance A: RESET_PC = 0x100
   logic        rst_a, rv_a, req_a, ov_a, or_a;
   logic [31:0] rpc_a, addr_a, rdata_a, opc_a, oin_a;
   // instance B: RESET_PC = 0xFFFF_FFF8
   logic        rst_b, rv_b, req_b, ov_b, or_b;
   logic [31:0] rpc_b, addr_b, rdata_b, opc_b, oin_b;
`ifdef IF_PERF_CNT_EN
   logic [31:0] pf_fetched_a, pf_flushed_a, pf_stall_a;
   logic [31:0] pf_fetched_b, pf_flushed_b, pf_stall_b;
`endif

   if_fetch_queue #(.RESET_PC(32'h0000_0100)) dut_a (
      .clk(clk), .rst(rst_a), .redirect_valid(rv_a), .redirect_pc(rpc_a),
      .imem_req(req_a), .imem_addr(addr_a), .imem_rdata(rdata_a),
      .out_valid(ov_a), .out_ready(or_a), .out_pc(opc_a), .out_insn(oin_a)
`ifdef IF_PERF_CNT_EN
      , .perf_fetched(pf_fetched_a), .perf_flushed(pf_flushed_a), .perf_stall(pf_stall_a)
`endif
   );

   if_fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
      .clk(clk), .rst(rst_b), .redirect_valid(rv_b), .redirect_pc(rpc_b),
      .imem_req(req_b), .imem_addr(addr_b), .imem_rdata(rdata_b),
      .out_valid(ov_b), .out_ready(or_b), .out_pc(opc_b), .out_insn(oin_b)
`ifdef IF_PERF_CNT_EN
      , .perf_fetched(pf_fetched_b), .perf_flushed(pf_flushed_b), .perf_stall(pf_stall_b)
`endif
   );

   // synchronous instruction memory, 1-cycle read latency
   always @(posedge clk) begin
      rdata_a <= addr_a ^ 32'h0000_A5A5;
      rdata_b <= addr_b ^ 32'h0000_A5A5;
   end

   int checks = 0;
   int errors = 0;
   int reqs;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // hold A in reset two cycles, release on a falling edge (start of cycle 0)
   task automatic reset_a(input logic ready);
      rst_a = 1'b0;
      rv_a  = 1'b0;
      or_a  = ready;
      tick();
      tick();
      rst_a = 1'b1;
      #1;
   endtask

   initial begin
      rst_a = 1'b0; rv_a = 1'b0; rpc_a = '0; or_a = 1'b1;
      rst_b = 1'b0; rv_b = 1'b0; rpc_b = '0; or_b = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;

      // reset state
      check("rst_req",  {31'd0, req_a}, 32'd0);
      check("rst_addr", addr_a, 32'h0000_0100);
      check("rst_valid", {31'd0, ov_a}, 32'd0);
      check("rst_pc",   opc_a, 32'd0);
      check("rst_insn", oin_a, 32'd0);
      check("rst_addr_b", addr_b, 32'hFFFF_FFF8);
`ifdef IF_PERF_CNT_EN
      check("rst_perf_fetched", pf_fetched_a, 32'd0);
      check("rst_perf_flushed", pf_flushed_a, 32'd0);
      check("rst_perf_stall",   pf_stall_a,   32'd0);
`endif

      // fill latency / steady stream (A) and PC wrap (B), released together
      @(negedge clk);
      rst_a = 1'b1;
      rst_b = 1'b1;
      #1;
      for (int c = 0; c < 6; c++) begin
         if (c < 4) begin
            check("s1_req",  {31'd0, req_a}, 32'd1);
            check("s1_addr", addr_a, 32'h0000_0100 + 32'(4 * c));
         end
         if (c < 2) check("s1_fill_valid", {31'd0, ov_a}, 32'd0);
         else begin
            check("s1_valid", {31'd0, ov_a}, 32'd1);
            check("s1_pc",    opc_a, 32'h0000_0100 + 32'(4 * (c - 2)));
            check("s1_insn",  oin_a, (32'h0000_0100 + 32'(4 * (c - 2))) ^ 32'h0000_A5A5);
         end
         if (c < 3) begin
            check("s5_req",  {31'd0, req_b}, 32'd1);
            check("s5_addr", addr_b, 32'hFFFF_FFF8 + 32'(4 * c));
         end
         if (c >= 2 && c < 5) begin
            check("s5_valid", {31'd0, ov_b}, 32'd1);
            check("s5_pc",    opc_b, 32'hFFFF_FFF8 + 32'(4 * (c - 2)));
            check("s5_insn",  oin_b, (32'hFFFF_FFF8 + 32'(4 * (c - 2))) ^ 32'h0000_A5A5);
         end
         tick();
         #1;
      end

      // credit back-pressure with decode stalled
      @(negedge clk);
      reset_a(1'b0);
      reqs = 0;
      for (int c = 0; c < 8; c++) begin
         if (req_a) reqs++;
         if (c >= 2) check("s2_hold_pc", opc_a, 32'h0000_0100);
         tick();
         #1;
      end
      check("s2_req_count", 32'(reqs), 32'd4);
      check("s2_req_idle", {31'd0, req_a}, 32'd0);
      or_a = 1'b1;
      #1;
      for (int k = 0; k < 6; k++) begin
         check("s2_valid", {31'd0, ov_a}, 32'd1);
         check("s2_pc", opc_a, 32'h0000_0100 + 32'(4 * k));
         if (k == 1) begin
            check("s2_resume_req",  {31'd0, req_a}, 32'd1);
            check("s2_resume_addr", addr_a, 32'h0000_0110);
         end
         tick();
         #1;
      end

      // redirect with 3 queued + 1 in flight
      @(negedge clk);
      reset_a(1'b0);
      for (int c = 0; c < 4; c++) tick();
      rv_a  = 1'b1;
      rpc_a = 32'h0000_2003;
      #1;
      check("s3_req",  {31'd0, req_a}, 32'd1);
      check("s3_addr", addr_a, 32'h0000_2000);
      tick();
      rv_a = 1'b0;
      #1;
      check("s3_flushed_valid", {31'd0, ov_a}, 32'd0);
`ifdef IF_PERF_CNT_EN
      check("s3_perf_flushed", pf_flushed_a, 32'd4);
`endif
      tick();
      #1;
      check("s3_valid", {31'd0, ov_a}, 32'd1);
      check("s3_insn",  oin_a, 32'h0000_85A5);
      or_a = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("s3_pc", opc_a, 32'h0000_2000 + 32'(4 * k));
         tick();
      end

      // redirect coinciding with a pop of 0x104
      reset_a(1'b1);
      for (int c = 0; c < 3; c++) tick();
      #1;
      check("s4_pop_valid", {31'd0, ov_a}, 32'd1);
      check("s4_pop_pc",    opc_a, 32'h0000_0104);
      rv_a  = 1'b1;
      rpc_a = 32'h0000_3000;
      #1;
      check("s4_addr", addr_a, 32'h0000_3000);
      tick();
      rv_a = 1'b0;
      #1;
      check("s4_flushed_valid", {31'd0, ov_a}, 32'd0);
`ifdef IF_PERF_CNT_EN
      check("s4_perf_fetched", pf_fetched_a, 32'd2);
      check("s4_perf_stall",   pf_stall_a,   32'd2);
`endif
      tick();
      #1;
      check("s4_valid", {31'd0, ov_a}, 32'd1);
      check("s4_pc",    opc_a, 32'h0000_3000);

      // asynchronous reset mid-stream, queue half full
      @(negedge clk);
      reset_a(1'b0);
      for (int c = 0; c < 3; c++) tick();
      #1;
      check("s6_pre_pc", opc_a, 32'h0000_0100);
      #2;
      rst_a = 1'b0;
      #1;
      check("s6_async_valid", {31'd0, ov_a}, 32'd0);
      check("s6_async_req",   {31'd0, req_a}, 32'd0);
      check("s6_async_addr",  addr_a, 32'h0000_0100);
      check("s6_async_pc",    opc_a, 32'd0);
      @(negedge clk);
      rst_a = 1'b1;
      #1;
      check("s6_restart_addr", addr_a, 32'h0000_0100);
      tick();
      #1;
      check("s6_no_stale", {31'd0, ov_a}, 32'd0);
      tick();
      #1;
      check("s6_valid", {31'd0, ov_a}, 32'd1);
      check("s6_pc",    opc_a, 32'h0000_0100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
